// File: rtl/vga_record_ctrl_pkg.sv
// Shared types for the record display controller: FSM encoding, BCD digit geometry and a digit validity helper.
package vga_record_ctrl_pkg;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 7;
  localparam int REC_W      = DIGIT_W * NUM_DIGITS;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  // True when every nibble of the record is a legal BCD digit (0..9).
  function automatic logic is_bcd(input logic [REC_W-1:0] rec);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (rec[i*DIGIT_W +: DIGIT_W] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/vga_record_store.sv
// DEPTH-entry record ring storage: one synchronous write port, one asynchronous read port.
// Write lands on the rising edge; read data follows raddr_i combinationally; no backpressure.
module vga_record_store
  import vga_record_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [REC_W-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [REC_W-1:0] rdata_o
);

  logic [REC_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/vga_record_ctrl.sv
// Keeps the last DEPTH BCD records, lets the user browse them and latches the selected one at frame start.
// Status outputs update one cycle after their cause; the display updates one cycle after frame_start; no backpressure.
module vga_record_ctrl
  import vga_record_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rec_valid,
  input  logic [REC_W-1:0] rec_digits,
  input  logic             btn_next,
  input  logic             btn_clr,
  input  logic             frame_start,
  output logic             has_record,
  output logic [REC_W-1:0] disp_digits,
  output logic [3:0]       rec_count,
  output logic [2:0]       sel_idx,
  output logic             full,
  output logic             rec_err
);

  localparam int              AW     = $clog2(DEPTH);
  localparam logic [3:0]      DEPTH4 = 4'(DEPTH);

  state_e           state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [2:0]       sel_q, sel_d;
  logic             full_q, full_d;
  logic             err_q, err_d;
  logic             has_q, has_d;
  logic [REC_W-1:0] disp_q, disp_d;

  logic             we;
  logic [3:0]       rd_sum;
  logic [AW-1:0]    rd_addr;
  logic [REC_W-1:0] rd_data;

  // Age 0 is the slot just behind the write pointer; sel < cnt <= DEPTH keeps rd_sum in range.
  assign rd_sum  = 4'(wr_ptr_q) + DEPTH4 - 4'd1 - 4'(sel_q);
  assign rd_addr = AW'(rd_sum % DEPTH4);

  vga_record_store #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_store (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (wr_ptr_q),
    .wdata_i (rec_digits),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    err_d    = 1'b0;
    has_d    = has_q;
    disp_d   = disp_q;
    we       = 1'b0;

    if (btn_clr) begin
      state_d  = ST_EMPTY;
      wr_ptr_d = '0;
      cnt_d    = 4'd0;
      sel_d    = 3'd0;
    end else if (rec_valid) begin
      if (is_bcd(rec_digits)) begin
        we       = 1'b1;
        state_d  = ST_HOLD;
        wr_ptr_d = wr_ptr_q + AW'(1);
        cnt_d    = (cnt_q == DEPTH4) ? cnt_q : cnt_q + 4'd1;
        sel_d    = 3'd0;
      end else begin
        err_d = 1'b1;
      end
    end else if (btn_next && state_q == ST_HOLD) begin
      sel_d = (4'(sel_q) == cnt_q - 4'd1) ? 3'd0 : sel_q + 3'd1;
    end

    full_d = (cnt_d == DEPTH4);

    // Shadow samples the pre-update state so a frame never shows a half-applied change.
    if (frame_start) begin
      has_d  = (state_q == ST_HOLD);
      disp_d = (state_q == ST_HOLD) ? rd_data : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      wr_ptr_q <= '0;
      cnt_q    <= 4'd0;
      sel_q    <= 3'd0;
      full_q   <= 1'b0;
      err_q    <= 1'b0;
      has_q    <= 1'b0;
      disp_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      full_q   <= full_d;
      err_q    <= err_d;
      has_q    <= has_d;
      disp_q   <= disp_d;
    end
  end

  assign has_record  = has_q;
  assign disp_digits = disp_q;
  assign rec_count   = cnt_q;
  assign sel_idx     = sel_q;
  assign full        = full_q;
  assign rec_err     = err_q;

endmodule

// File: tb/tb_vga_record_ctrl.sv
// Directed bench for vga_record_ctrl: history-queue model checked every cycle plus hand-computed spot checks.
module tb_vga_record_ctrl;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rec_valid   = 1'b0;
  logic [27:0] rec_digits  = '0;
  logic        btn_next    = 1'b0;
  logic        btn_clr     = 1'b0;
  logic        frame_start = 1'b0;
  logic        has_record;
  logic [27:0] disp_digits;
  logic [3:0]  rec_count;
  logic [2:0]  sel_idx;
  logic        full;
  logic        rec_err;

  int n_tests = 0;
  int n_fail  = 0;
  bit started = 0;

  // Model: newest record at index 0, at most DEPTH entries.
  logic [27:0] hist[$];
  int          m_sel;
  logic        m_has;
  logic [27:0] m_disp;
  logic        m_err;

  vga_record_ctrl #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .rec_valid   (rec_valid),
    .rec_digits  (rec_digits),
    .btn_next    (btn_next),
    .btn_clr     (btn_clr),
    .frame_start (frame_start),
    .has_record  (has_record),
    .disp_digits (disp_digits),
    .rec_count   (rec_count),
    .sel_idx     (sel_idx),
    .full        (full),
    .rec_err     (rec_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit digits_ok(input logic [27:0] d);
    logic [27:0] v;
    v = d;
    for (int k = 0; k < 7; k++) begin
      if ((v & 28'hF) >= 28'd10) return 0;
      v = v >> 4;
    end
    return 1;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_sel  = 0;
    m_has  = 1'b0;
    m_disp = '0;
    m_err  = 1'b0;
  endtask

  task automatic model_step(input logic rv, input logic [27:0] d, input logic nx,
                            input logic clr, input logic fs);
    if (fs) begin
      m_has  = (hist.size() > 0);
      m_disp = m_has ? hist[m_sel] : 28'h0;
    end
    m_err = 1'b0;
    if (clr) begin
      hist.delete();
      m_sel = 0;
    end else if (rv) begin
      if (digits_ok(d)) begin
        hist.push_front(d);
        if (hist.size() > DEPTH) void'(hist.pop_back());
        m_sel = 0;
      end else begin
        m_err = 1'b1;
      end
    end else if (nx && hist.size() > 0) begin
      m_sel = (m_sel + 1) % hist.size();
    end
  endtask

  // One clock cycle of stimulus; returns shortly after the following falling edge.
  task automatic cyc(input logic rv, input logic [27:0] d, input logic nx,
                     input logic clr, input logic fs);
    rec_valid   = rv;
    rec_digits  = d;
    btn_next    = nx;
    btn_clr     = clr;
    frame_start = fs;
    @(posedge clk);
    model_step(rv, d, nx, clr, fs);
    @(negedge clk);
    #1;
    rec_valid   = 1'b0;
    btn_next    = 1'b0;
    btn_clr     = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic wr(input logic [27:0] d);  cyc(1'b1, d, 1'b0, 1'b0, 1'b0); endtask
  task automatic frame();                   cyc(1'b0, '0, 1'b0, 1'b0, 1'b1); endtask
  task automatic nxt();                     cyc(1'b0, '0, 1'b1, 1'b0, 1'b0); endtask
  task automatic idle();                    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0); endtask

  always @(negedge clk) begin
    if (started) begin
      chk("has_record", 32'(has_record), 32'(m_has));
      chk("disp_digits", 32'(disp_digits), 32'(m_disp));
      chk("rec_count", 32'(rec_count), 32'(hist.size()));
      chk("sel_idx", 32'(sel_idx), 32'(m_sel));
      chk("full", 32'(full), 32'(hist.size() == DEPTH));
      chk("rec_err", 32'(rec_err), 32'(m_err));
    end
  end

  initial begin
    rst = 1'b1;
    model_reset();
    started = 1;
    @(negedge clk);
    #1 rst = 1'b0;

    frame();
    chk("lit_reset_has", 32'(has_record), 32'd0);
    chk("lit_reset_disp", 32'(disp_digits), 32'd0);
    chk("lit_reset_cnt", 32'(rec_count), 32'd0);

    wr(28'h0012345);
    frame();
    chk("lit_first_has", 32'(has_record), 32'd1);
    chk("lit_first_disp", 32'(disp_digits), 32'h0012345);
    chk("lit_first_sel", 32'(sel_idx), 32'd0);
    chk("lit_first_cnt", 32'(rec_count), 32'd1);

    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) wr(28'(i));
    chk("lit_full", 32'(full), 32'd1);
    chk("lit_full_cnt", 32'(rec_count), 32'd4);
    frame();
    chk("lit_newest", 32'(disp_digits), 32'h5);
    nxt(); frame(); chk("lit_browse1", 32'(disp_digits), 32'h4);
    nxt(); frame(); chk("lit_browse2", 32'(disp_digits), 32'h3);
    nxt(); frame(); chk("lit_browse3", 32'(disp_digits), 32'h2);
    nxt(); frame(); chk("lit_browse_wrap", 32'(disp_digits), 32'h5);
    chk("lit_wrap_sel", 32'(sel_idx), 32'd0);

    wr(28'h000000A);
    chk("lit_err_pulse", 32'(rec_err), 32'd1);
    chk("lit_err_cnt", 32'(rec_count), 32'd4);
    idle();
    chk("lit_err_gone", 32'(rec_err), 32'd0);
    chk("lit_err_disp", 32'(disp_digits), 32'h5);

    // Frame coinciding with a write shows the old record; next frame shows the new one.
    cyc(1'b1, 28'h0000777, 1'b0, 1'b0, 1'b1);
    chk("lit_coinc_wr_old", 32'(disp_digits), 32'h5);
    frame();
    chk("lit_coinc_wr_new", 32'(disp_digits), 32'h777);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
    chk("lit_coinc_nx_old", 32'(disp_digits), 32'h777);
    frame();
    chk("lit_coinc_nx_new", 32'(disp_digits), 32'h5);

    // Clear beats a same-cycle write; the frame still shows the pre-clear record.
    cyc(1'b1, 28'h0001234, 1'b0, 1'b1, 1'b1);
    chk("lit_clr_old_has", 32'(has_record), 32'd1);
    chk("lit_clr_old_disp", 32'(disp_digits), 32'h5);
    chk("lit_clr_cnt", 32'(rec_count), 32'd0);
    frame();
    chk("lit_clr_has", 32'(has_record), 32'd0);
    chk("lit_clr_disp", 32'(disp_digits), 32'd0);

    nxt();
    chk("lit_empty_next", 32'(sel_idx), 32'd0);

    wr(28'h9876543);
    wr(28'h0000099);
    nxt();
    chk("lit_two_sel", 32'(sel_idx), 32'd1);
    nxt();
    chk("lit_two_wrap", 32'(sel_idx), 32'd0);

    // Asynchronous reset between a write and the next frame.
    rst = 1'b1;
    model_reset();
    #2 rst = 1'b0;
    frame();
    chk("lit_rst_has", 32'(has_record), 32'd0);
    chk("lit_rst_cnt", 32'(rec_count), 32'd0);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_record_ctrl.md
VGA_RECORD_CTRL -- requirements
Module: vga_record_ctrl

Interface
REQ-001 Parameter DEPTH, default 4, number of stored records (power of two, 2..8).
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 rec_valid  input  1  one-cycle pulse: new record offered on rec_digits.
REQ-005 rec_digits  input  28  seven BCD digits; [3:0] = led1 (least significant) ... [27:24] = led7.
REQ-006 btn_next  input  1  one-cycle debounced pulse: browse to next-older record.
REQ-007 btn_clr  input  1  one-cycle pulse: erase all records.
REQ-008 frame_start  input  1  one-cycle pulse at start of vertical blank.
REQ-009 has_record  output  1  displayed record is valid.
REQ-010 disp_digits  output  28  displayed record, same packing as rec_digits.
REQ-011 rec_count  output  4  number of stored records, 0..DEPTH.
REQ-012 sel_idx  output  3  age of selected record: 0 = newest.
REQ-013 full  output  1  rec_count == DEPTH.
REQ-014 rec_err  output  1  one-cycle pulse: offered record rejected.

Function
REQ-015 Storage SHALL be a DEPTH-entry ring buffer with write pointer wr_ptr and counter cnt.
REQ-016 Accepted record SHALL be written at wr_ptr; wr_ptr SHALL increment modulo DEPTH; cnt SHALL increment, saturating at DEPTH (oldest overwritten when full).
REQ-017 A rec_valid whose rec_digits contains any nibble > 9 SHALL be ignored, with rec_err high for exactly the following cycle.
REQ-018 On every accepted write, sel_idx SHALL reset to 0.
REQ-019 btn_next SHALL increment sel_idx; when sel_idx == cnt-1 it SHALL wrap to 0; btn_next with cnt == 0 SHALL have no effect.
REQ-020 Selected entry address SHALL be (wr_ptr - 1 - sel_idx) modulo DEPTH.
REQ-021 Control FSM states: EMPTY (cnt == 0) and HOLD (cnt > 0); EMPTY->HOLD on accepted write; HOLD->EMPTY on btn_clr.
REQ-022 btn_clr SHALL zero cnt, wr_ptr and sel_idx in the next cycle; storage contents need not be erased.
REQ-023 Priority within one cycle: btn_clr > rec_valid > btn_next; lower-priority inputs in that cycle SHALL be discarded.
REQ-024 disp_digits and has_record SHALL be shadow registers loaded only in the cycle after frame_start is sampled high, from the state in effect on that same edge (tear-free display).
REQ-025 Shadow load in EMPTY SHALL set has_record = 0 and disp_digits = 0.
REQ-026 Shadow load in HOLD SHALL set has_record = 1 and disp_digits = selected entry.
REQ-027 frame_start coinciding with rec_valid, btn_next or btn_clr SHALL display the pre-update state; the change appears at the following frame_start.
REQ-028 rec_count, sel_idx and full SHALL be registered and update in the cycle after the causing event, independent of frame_start.

Reset
REQ-029 rst SHALL immediately force: FSM = EMPTY, wr_ptr = 0, cnt = 0, sel_idx = 0, has_record = 0, disp_digits = 0, rec_err = 0, full = 0.
REQ-030 rst asserted mid-operation SHALL discard any pending shadow update; storage RAM needs no reset.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding, the BCD digit width (4) and the digit count (7).
REQ-032 The ring buffer SHALL be a sub-module vga_record_store (write port plus one asynchronous read port); FSM, pointers and shadow registers stay in the top.

Verification
REQ-033 Reset, then frame_start -> has_record = 0, disp_digits = 0, rec_count = 0.
REQ-034 Write 0x0012345, then frame_start -> has_record = 1, disp_digits = 0x0012345, sel_idx = 0, rec_count = 1.
REQ-035 DEPTH=4: write records 1,2,3,4,5 -> full = 1, rec_count = 4; four btn_next pulses, each followed by frame_start -> displays 4,3,2, then 5 (wrap to newest).
REQ-036 rec_digits = 0x000000A with rec_valid -> rec_err pulses one cycle; rec_count and display unchanged.
REQ-037 btn_clr and rec_valid in the same cycle as frame_start -> that frame shows the old record; the next frame_start gives has_record = 0 and rec_count = 0.
REQ-038 rst pulse between a write and the next frame_start -> has_record stays 0 after that frame_start.
